// File: rtl/imm_pkg.sv
// Shared constants for the pipelined immediate generator.
// Format select encodings and the legal-XLEN check.
package imm_pkg;

    localparam int IMM_SRC_W = 3;

    localparam logic [IMM_SRC_W-1:0] IMM_I = 3'b000;
    localparam logic [IMM_SRC_W-1:0] IMM_S = 3'b001;
    localparam logic [IMM_SRC_W-1:0] IMM_B = 3'b010;
    localparam logic [IMM_SRC_W-1:0] IMM_J = 3'b011;
    localparam logic [IMM_SRC_W-1:0] IMM_U = 3'b100;
    localparam logic [IMM_SRC_W-1:0] IMM_Z = 3'b101;

    function automatic bit xlen_ok(input int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extraction from instruction bits [31:7].
// instr[k] is instruction bit k+7; unknown formats yield zero and err.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [24:0]          instr,
    input  logic [IMM_SRC_W-1:0] imm_src,
    output logic [XLEN-1:0]      imm,
    output logic                 err
);

    logic [11:0] w_i;
    logic [11:0] w_s;
    logic [12:0] w_b;
    logic [20:0] w_j;
    logic [31:0] w_u;
    logic [4:0]  w_z;

    assign w_i = instr[24:13];
    assign w_s = {instr[24:18], instr[4:0]};
    assign w_b = {instr[24], instr[0], instr[23:18], instr[4:1], 1'b0};
    assign w_j = {instr[24], instr[12:5], instr[13], instr[23:14], 1'b0};
    assign w_u = {instr[24:5], 12'b0};
    assign w_z = instr[12:8];

    // Select and extend the field for the requested format
    always_comb begin
        imm = '0;
        err = 1'b0;
        case (imm_src)
            IMM_I:   imm = XLEN'($signed(w_i));
            IMM_S:   imm = XLEN'($signed(w_s));
            IMM_B:   imm = XLEN'($signed(w_b));
            IMM_J:   imm = XLEN'($signed(w_j));
            IMM_U:   imm = XLEN'($signed(w_u));
            IMM_Z:   imm = XLEN'(w_z);
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator with a valid/ready output register
// plus one skid entry, flush, tag passthrough and illegal-format counter.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int TAG_W     = 32,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [24:0]          instr,
    input  logic [IMM_SRC_W-1:0] imm_src,
    input  logic [TAG_W-1:0]     in_tag,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      imm,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    generate
        if (!xlen_ok(XLEN)) begin : g_bad_xlen
            $error("imm_gen_pipe: XLEN must be 32 or 64");
        end
    endgenerate

    logic [XLEN-1:0]      w_imm;
    logic                 w_err;
    logic                 w_in_xfer;
    logic                 w_out_xfer;
    logic                 w_load_in;
    logic                 w_load_skid;

    logic                 r_out_valid;
    logic [XLEN-1:0]      r_imm;
    logic [TAG_W-1:0]     r_tag;
    logic                 r_err;
    logic                 r_skid_valid;
    logic [XLEN-1:0]      r_skid_imm;
    logic [TAG_W-1:0]     r_skid_tag;
    logic                 r_skid_err;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    imm_decode #(
        .XLEN(XLEN)
    ) u_dec (
        .instr  (instr),
        .imm_src(imm_src),
        .imm    (w_imm),
        .err    (w_err)
    );

    assign in_ready    = !r_skid_valid;
    assign w_in_xfer   = in_valid && in_ready;
    assign w_out_xfer  = r_out_valid && out_ready;
    assign w_load_in   = w_in_xfer && (!r_out_valid || w_out_xfer);
    assign w_load_skid = w_in_xfer && r_out_valid && !w_out_xfer;

    assign out_valid = r_out_valid;
    assign imm       = r_imm;
    assign out_tag   = r_tag;
    assign out_err   = r_err;
    assign err_count = r_err_cnt;

    // Output register and skid entry; flush empties both
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_imm        <= '0;
            r_tag        <= '0;
            r_err        <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_imm   <= '0;
            r_skid_tag   <= '0;
            r_skid_err   <= 1'b0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else begin
            if (w_load_in) begin
                r_out_valid <= 1'b1;
                r_imm       <= w_imm;
                r_tag       <= in_tag;
                r_err       <= w_err;
            end else if (w_out_xfer && r_skid_valid) begin
                r_imm <= r_skid_imm;
                r_tag <= r_skid_tag;
                r_err <= r_skid_err;
            end else if (w_out_xfer) begin
                r_out_valid <= 1'b0;
            end
            if (w_load_skid) begin
                r_skid_valid <= 1'b1;
                r_skid_imm   <= w_imm;
                r_skid_tag   <= in_tag;
                r_skid_err   <= w_err;
            end else if (w_out_xfer) begin
                r_skid_valid <= 1'b0;
            end
        end
    end

    // Saturating count of accepted illegal formats, not cleared by flush
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_cnt <= '0;
        end else if (w_in_xfer && !flush && w_err && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: XLEN=32 instance and an
// XLEN=64 instance with a 2-bit error counter.
module tb_imm_gen_pipe;

    typedef struct packed {
        logic [63:0] imm;
        logic [31:0] tag;
        logic        err;
    } exp_t;

    logic clk;
    logic rst;

    logic        a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
    logic [24:0] a_instr;
    logic [2:0]  a_src;
    logic [31:0] a_tag, a_out_tag, a_imm;
    logic        a_out_err;
    logic [7:0]  a_err_count;

    logic        b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
    logic [24:0] b_instr;
    logic [2:0]  b_src;
    logic [31:0] b_tag, b_out_tag;
    logic [63:0] b_imm;
    logic        b_out_err;
    logic [1:0]  b_err_count;

    exp_t a_pend, b_pend;
    exp_t qa[$];
    exp_t qb[$];
    int   total;
    int   bad;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32), .ERR_CNT_W(8)) dut_a (
        .clk(clk), .reset(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .instr(a_instr), .imm_src(a_src), .in_tag(a_tag),
        .flush(a_flush),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .imm(a_imm), .out_tag(a_out_tag), .out_err(a_out_err),
        .err_count(a_err_count)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32), .ERR_CNT_W(2)) dut_b (
        .clk(clk), .reset(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .instr(b_instr), .imm_src(b_src), .in_tag(b_tag),
        .flush(b_flush),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .imm(b_imm), .out_tag(b_out_tag), .out_err(b_out_err),
        .err_count(b_err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Monitor + input tracker for instance A
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            qa.delete();
        end else begin
            if (a_out_valid && a_out_ready) begin
                total++;
                if (qa.size() == 0) begin
                    bad++;
                    $display("FAIL a_unexpected_out tag=%h", a_out_tag);
                end else begin
                    total--;
                    e = qa.pop_front();
                    chk("a_imm", 64'(a_imm), e.imm);
                    chk("a_tag", 64'(a_out_tag), 64'(e.tag));
                    chk("a_err", 64'(a_out_err), 64'(e.err));
                end
            end
            if (a_flush) qa.delete();
            else if (a_in_valid && a_in_ready) qa.push_back(a_pend);
        end
    end

    // Monitor + input tracker for instance B
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            qb.delete();
        end else begin
            if (b_out_valid && b_out_ready) begin
                total++;
                if (qb.size() == 0) begin
                    bad++;
                    $display("FAIL b_unexpected_out tag=%h", b_out_tag);
                end else begin
                    total--;
                    e = qb.pop_front();
                    chk("b_imm", b_imm, e.imm);
                    chk("b_tag", 64'(b_out_tag), 64'(e.tag));
                    chk("b_err", 64'(b_out_err), 64'(e.err));
                end
            end
            if (b_flush) qb.delete();
            else if (b_in_valid && b_in_ready) qb.push_back(b_pend);
        end
    end

    task automatic put_a(input logic [31:0] ins, input logic [2:0] src,
                         input logic [31:0] tag, input logic [63:0] ei,
                         input logic ee);
        logic [31:0] w;
        w          = ins;
        a_in_valid = 1'b1;
        a_instr    = w[31:7];
        a_src      = src;
        a_tag      = tag;
        a_pend     = '{imm: ei, tag: tag, err: ee};
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (a_in_ready) break;
            if (n == 19) begin
                total++;
                bad++;
                $display("FAIL a_accept_timeout tag=%h", tag);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic put_b(input logic [31:0] ins, input logic [2:0] src,
                         input logic [31:0] tag, input logic [63:0] ei,
                         input logic ee);
        logic [31:0] w;
        w          = ins;
        b_in_valid = 1'b1;
        b_instr    = w[31:7];
        b_src      = src;
        b_tag      = tag;
        b_pend     = '{imm: ei, tag: tag, err: ee};
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (b_in_ready) break;
            if (n == 19) begin
                total++;
                bad++;
                $display("FAIL b_accept_timeout tag=%h", tag);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1;
        a_in_valid = 0; a_instr = '0; a_src = '0; a_tag = '0;
        a_flush = 0; a_out_ready = 1; a_pend = '0;
        b_in_valid = 0; b_instr = '0; b_src = '0; b_tag = '0;
        b_flush = 0; b_out_ready = 1; b_pend = '0;

        cyc(3);
        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_in_ready", 64'(a_in_ready), 64'd1);
        chk("rst_imm", 64'(a_imm), 64'd0);
        chk("rst_tag", 64'(a_out_tag), 64'd0);
        chk("rst_err", 64'(a_out_err), 64'd0);
        chk("rst_err_count", 64'(a_err_count), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc(1);

        // Single I-format, one-cycle latency
        put_a(32'hFFF00093, 3'b000, 32'h1, 64'hFFFF_FFFF, 1'b0);
        a_in_valid = 0;
        chk("lat_out_valid", 64'(a_out_valid), 64'd1);
        chk("lat_imm", 64'(a_imm), 64'hFFFF_FFFF);
        cyc(2);

        // Back-to-back formats
        put_a(32'hFE512C23, 3'b001, 32'h2, 64'hFFFF_FFF8, 1'b0);
        put_a(32'hFFDFF06F, 3'b011, 32'h3, 64'hFFFF_FFFC, 1'b0);
        put_a(32'h000FD073, 3'b101, 32'h4, 64'h0000_001F, 1'b0);
        put_a(32'hFE000EE3, 3'b010, 32'h5, 64'hFFFF_FFFC, 1'b0);
        put_a(32'h800000B7, 3'b100, 32'h6, 64'h8000_0000, 1'b0);
        a_in_valid = 0;
        cyc(3);

        // Back-pressure: two accepted, third held off
        a_out_ready = 0;
        put_a(32'h00100093, 3'b000, 32'h10, 64'h1, 1'b0);
        put_a(32'h7FF00093, 3'b000, 32'h11, 64'h7FF, 1'b0);
        chk("stall_in_ready", 64'(a_in_ready), 64'd0);
        a_instr = 25'h1FF_FFFF;
        a_tag   = 32'h12;
        a_pend  = '{imm: 64'hFFFF_FFFF, tag: 32'h12, err: 1'b0};
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("stall_hold_ready", 64'(a_in_ready), 64'd0);
            chk("stall_hold_imm", 64'(a_imm), 64'h1);
            chk("stall_hold_tag", 64'(a_out_tag), 64'h10);
        end
        a_in_valid  = 0;
        a_out_ready = 1;
        cyc(4);

        // Illegal formats
        put_a(32'h12345678, 3'b110, 32'h20, 64'h0, 1'b1);
        put_a(32'h12345678, 3'b111, 32'h21, 64'h0, 1'b1);
        a_in_valid = 0;
        cyc(2);
        chk("err_count_2", 64'(a_err_count), 64'd2);

        // Flush at occupancy 2 with a same-cycle input
        a_out_ready = 0;
        put_a(32'h00300093, 3'b000, 32'h30, 64'h3, 1'b0);
        put_a(32'h00400093, 3'b000, 32'h31, 64'h4, 1'b0);
        a_flush = 1; a_src = 3'b110;
        cyc(1);
        a_flush = 0; a_in_valid = 0;
        chk("flush2_out_valid", 64'(a_out_valid), 64'd0);
        chk("flush2_in_ready", 64'(a_in_ready), 64'd1);
        chk("flush2_err_count", 64'(a_err_count), 64'd2);

        // Flush at occupancy 0 beats an acceptable illegal input
        a_flush = 1; a_in_valid = 1; a_src = 3'b111;
        cyc(1);
        a_flush = 0; a_in_valid = 0;
        chk("flush0_out_valid", 64'(a_out_valid), 64'd0);
        chk("flush0_err_count", 64'(a_err_count), 64'd2);
        a_out_ready = 1;
        cyc(3);
        chk("flush_drained", 64'(a_out_valid), 64'd0);

        // Asynchronous reset mid-stream
        a_out_ready = 0;
        put_a(32'hFFF00093, 3'b000, 32'h55, 64'hFFFF_FFFF, 1'b0);
        a_in_valid = 0;
        #1 rst = 1'b1;
        #1;
        chk("arst_out_valid", 64'(a_out_valid), 64'd0);
        chk("arst_in_ready", 64'(a_in_ready), 64'd1);
        chk("arst_imm", 64'(a_imm), 64'd0);
        chk("arst_tag", 64'(a_out_tag), 64'd0);
        chk("arst_err_count", 64'(a_err_count), 64'd0);
        @(negedge clk);
        qa.delete();
        #1 rst = 1'b0;
        a_out_ready = 1;
        cyc(2);

        // XLEN=64 instance
        put_b(32'h800000B7, 3'b100, 32'h40, 64'hFFFF_FFFF_8000_0000, 1'b0);
        put_b(32'hFE000EE3, 3'b010, 32'h41, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        put_b(32'hFFF00093, 3'b000, 32'h42, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        put_b(32'hFE512C23, 3'b001, 32'h43, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
        put_b(32'h000FD073, 3'b101, 32'h44, 64'h0000_0000_0000_001F, 1'b0);
        for (int i = 0; i < 5; i++) begin
            put_b(32'h0, 3'b110, 32'h50 + i, 64'h0, 1'b1);
        end
        b_in_valid = 0;
        cyc(3);
        chk("b_err_sat", 64'(b_err_count), 64'd3);

        for (int i = 0; i < 50; i++) begin
            if (qa.size() == 0 && qb.size() == 0) break;
            cyc(1);
        end
        chk("queues_empty", 64'(qa.size() + qb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
